// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshakes, the UART_Tx byte-engine link and
// the status outputs of uart_tx_arbiter, bundled into one interface.
// slave  = arbiter side, master = requesters/UART_Tx/observer side.
interface uart_tx_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        grant_id;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic [15:0] words_sent;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_active, tx_done,
    output req0_ready, req1_ready, grant_id, busy, tx_dv, tx_byte, words_sent
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_active, tx_done,
    input  req0_ready, req1_ready, grant_id, busy, tx_dv, tx_byte, words_sent
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_Tx byte engine between two 32-bit word
// requesters. A granted word is sent LSB byte first as four UART_Tx
// transfers, with GAP_CLKS idle clocks after each byte's tx_done.
// Build option: define UART_ARB_FIXED_PRIORITY_EN so requester 0 always wins
// a tie; by default ties are resolved round-robin.
//
// state | meaning
// IDLE  | no word held; arbitrate once UART_Tx is quiet
// SEND  | pulse tx_dv with byte byte_cnt of word_buf
// WAIT  | byte in flight, waiting for tx_done
// GAP   | idle clocks after a byte before the next decision
module uart_tx_arbiter #(
  parameter logic [15:0] GAP_CLKS = 16'd16,
  parameter int          GAP_BITS = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [GAP_BITS-1:0] GAP_ONE  = 1;
  localparam logic [GAP_BITS-1:0] GAP_LAST = GAP_BITS'(GAP_CLKS) - GAP_ONE;

  logic [1:0]          state;
  logic [1:0]          byte_cnt;
  logic [GAP_BITS-1:0] gap_cnt;
  logic [31:0]         word_buf;
  logic                pick;
  logic                step;
`ifndef UART_ARB_FIXED_PRIORITY_EN
  logic                last_grant;
`endif

  // Choose which requester wins if a grant happens this cycle.
  always_comb begin
    pick = 1'b0;
`ifdef UART_ARB_FIXED_PRIORITY_EN
    pick = !bus.req0_valid;
`else
    pick = bus.req1_valid && (!bus.req0_valid || !last_grant);
`endif
  end

  // A byte is fully finished (gap included); decide next byte or word end.
  always_comb begin
    step = 1'b0;
    if (state == WAIT && bus.tx_done && GAP_CLKS == 16'd0) step = 1'b1;
    if (state == GAP && gap_cnt == GAP_LAST) step = 1'b1;
  end

  // Arbitration, byte sequencing and gap timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      byte_cnt       <= 2'd0;
      gap_cnt        <= '0;
      word_buf       <= 32'h0;
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
      bus.grant_id   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.tx_dv      <= 1'b0;
      bus.tx_byte    <= 8'h00;
      bus.words_sent <= 16'h0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
      bus.tx_dv      <= 1'b0;
      case (state)
        IDLE: begin
          // Hold off while a byte from an abandoned word may still be shifting.
          if (!bus.tx_active && (bus.req0_valid || bus.req1_valid)) begin
            word_buf       <= pick ? bus.req1_data : bus.req0_data;
            bus.req0_ready <= !pick;
            bus.req1_ready <= pick;
            bus.grant_id   <= pick;
            bus.busy       <= 1'b1;
            byte_cnt       <= 2'd0;
            state          <= SEND;
`ifndef UART_ARB_FIXED_PRIORITY_EN
            last_grant     <= pick;
`endif
          end
        end
        SEND: begin
          if (!bus.tx_active) begin
            bus.tx_dv   <= 1'b1;
            bus.tx_byte <= word_buf[{byte_cnt, 3'b000} +: 8];
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.tx_done && GAP_CLKS != 16'd0) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GAP_ONE;
        end
        default: state <= IDLE;
      endcase

      if (step) begin
        if (byte_cnt == 2'd3) begin
          bus.words_sent <= bus.words_sent + 16'd1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          state    <= SEND;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter. dut_a runs with
// GAP_CLKS=4 and a scoreboard monitor; dut_b runs with GAP_CLKS=0 for the
// zero-gap and stray tx_done cases.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int GAP_A  = 4;
  localparam int TX_LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if bus_a();
  uart_tx_arbiter_if bus_b();

  logic act_a = 1'b0, done_a = 1'b0;
  logic act_b = 1'b0, done_b_m = 1'b0, done_b_inj = 1'b0;
  assign bus_a.tx_active = act_a;
  assign bus_a.tx_done   = done_a;
  assign bus_b.tx_active = act_b;
  assign bus_b.tx_done   = done_b_m | done_b_inj;

  uart_tx_arbiter #(.GAP_CLKS(16'd4), .GAP_BITS(16)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  uart_tx_arbiter #(.GAP_CLKS(16'd0), .GAP_BITS(16)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no event, expected one (cycle %0d)", name, cyc);
  endtask

  // UART_Tx models: tx_done pulses in the 10th clock counted from the tx_dv clock.
  int cnt_a = 0;
  always @(negedge clk) begin
    #1;
    done_a = 1'b0;
    if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) begin done_a = 1'b1; act_a = 1'b0; end
    end else if (bus_a.tx_dv) begin
      cnt_a = TX_LAT - 1; act_a = 1'b1;
    end
  end

  int cnt_b = 0, done_b_cyc = 0;
  always @(negedge clk) begin
    #1;
    done_b_m = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) begin done_b_m = 1'b1; act_b = 1'b0; done_b_cyc = cyc; end
    end else if (bus_b.tx_dv) begin
      cnt_b = TX_LAT - 1; act_b = 1'b1;
    end
  end

  // Scoreboard for dut_a.
  typedef struct { logic g; logic [7:0] b; int idx; } exp_t;
  exp_t exp_byte[$];
  logic exp_grant[$];
  exp_t mon_e;
  int   dv_count = 0, last_dv_cyc = 0, ready_count = 0;

  task automatic push_word(input logic g, input logic [31:0] w);
    exp_grant.push_back(g);
    for (int i = 0; i < 4; i++) exp_byte.push_back('{g, w[8*i +: 8], i});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.req0_ready && bus_a.req1_ready) begin
        check("dual_ready", 32'(bus_a.req1_ready), 32'd0);
      end else if (bus_a.req0_ready || bus_a.req1_ready) begin
        ready_count++;
        if (exp_grant.size() == 0) fail("expected_grant_queued");
        else check("ready_id", 32'(bus_a.req1_ready), 32'(exp_grant.pop_front()));
      end
      if (bus_a.tx_dv) begin
        check("dv_while_active", 32'(act_a), 32'd0);
        dv_count++;
        if (exp_byte.size() == 0) fail("expected_byte_queued");
        else begin
          mon_e = exp_byte.pop_front();
          check("tx_byte", 32'(bus_a.tx_byte), 32'(mon_e.b));
          check("grant_id", 32'(bus_a.grant_id), 32'(mon_e.g));
          if (mon_e.idx != 0) check("dv_spacing", cyc - last_dv_cyc, TX_LAT + GAP_A + 1);
        end
        last_dv_cyc = cyc;
      end
    end
  end

  function automatic logic cond_a(input int what, input int arg);
    case (what)
      0: return bus_a.req0_ready;
      1: return bus_a.req1_ready;
      2: return !bus_a.busy;
      3: return dv_count >= arg;
      4: return ready_count >= arg;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_a(input int what, input int arg, input string name);
    int n = 0;
    while (!cond_a(what, arg) && n < 500) begin @(negedge clk); n++; end
    if (!cond_a(what, arg)) fail({"timeout_", name});
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_req0_ready"}, 32'(bus_a.req0_ready), 32'd0);
    check({tag, "_req1_ready"}, 32'(bus_a.req1_ready), 32'd0);
    check({tag, "_grant_id"},   32'(bus_a.grant_id),   32'd0);
    check({tag, "_busy"},       32'(bus_a.busy),       32'd0);
    check({tag, "_tx_dv"},      32'(bus_a.tx_dv),      32'd0);
    check({tag, "_tx_byte"},    32'(bus_a.tx_byte),    32'd0);
    check({tag, "_words_sent"}, 32'(bus_a.words_sent), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   base, n, act;
    logic seen;
    logic [31:0] wb;
    bus_a.req0_valid = 0; bus_a.req1_valid = 0; bus_a.req0_data = 0; bus_a.req1_data = 0;
    bus_b.req0_valid = 0; bus_b.req1_valid = 0; bus_b.req0_data = 0; bus_b.req1_data = 0;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;

    // Single word.
    push_word(1'b0, 32'hA1B2C3D4);
    bus_a.req0_data = 32'hA1B2C3D4; bus_a.req0_valid = 1'b1;
    wait_a(0, 0, "ready0_single");
    bus_a.req0_valid = 1'b0;
    check("busy_after_grant", 32'(bus_a.busy), 32'd1);
    wait_a(2, 0, "busy_fall_single");
    check("busy_fall_timing", cyc - last_dv_cyc, TX_LAT + GAP_A);
    check("words_single", 32'(bus_a.words_sent), 32'd1);
    check("ready_once", ready_count, 1);
    check("dv_count_single", dv_count, 4);

    // Both requesters continuously valid.
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    ready_count = 0;
`ifdef UART_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) push_word(1'b0, 32'h11111111);
`else
    for (int i = 0; i < 4; i++) push_word(i[0], i[0] ? 32'h22222222 : 32'h11111111);
`endif
    bus_a.req0_data = 32'h11111111; bus_a.req1_data = 32'h22222222;
    bus_a.req0_valid = 1'b1; bus_a.req1_valid = 1'b1;
    wait_a(4, 4, "four_grants");
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
    wait_a(2, 0, "busy_fall_rr");
    check("words_rr", 32'(bus_a.words_sent), 32'd4);
    check("grants_consumed_rr", exp_grant.size(), 0);

    // Late request from requester 1 during byte 2 of a requester 0 word.
    push_word(1'b0, 32'hCAFEF00D);
    bus_a.req0_data = 32'hCAFEF00D; bus_a.req0_valid = 1'b1;
    wait_a(0, 0, "ready0_late");
    bus_a.req0_valid = 1'b0;
    base = dv_count;
    wait_a(3, base + 2, "byte2_late");
    push_word(1'b1, 32'h5A5AA5A5);
    bus_a.req1_data = 32'h5A5AA5A5; bus_a.req1_valid = 1'b1;
    seen = 1'b0; n = 0;
    while (bus_a.busy && n < 500) begin
      if (bus_a.req1_ready) seen = 1'b1;
      @(negedge clk); n++;
    end
    check("late_ready_held", 32'(seen), 32'd0);
    if (bus_a.busy) fail("timeout_late_busy");
    @(negedge clk);
    check("late_ready_next_idle", 32'(bus_a.req1_ready), 32'd1);
    bus_a.req1_valid = 1'b0;
    @(negedge clk);
    wait_a(2, 0, "busy_fall_late");
    check("words_late", 32'(bus_a.words_sent), 32'd6);

    // Reset in the middle of a word while UART_Tx is still shifting.
    push_word(1'b0, 32'hA1B2C3D4);
    bus_a.req0_data = 32'hA1B2C3D4; bus_a.req0_valid = 1'b1;
    wait_a(0, 0, "ready0_midreset");
    base = dv_count;
    wait_a(3, base + 2, "byte2_midreset");
    @(negedge clk);
    rst = 1'b1; cnt_a = 6; act_a = 1'b1;
    exp_byte.delete();
    push_word(1'b0, 32'hA1B2C3D4);
    @(negedge clk);
    check_reset_a("midreset");
    rst = 1'b0;
    wait_a(0, 0, "regrant_midreset");
    check("regrant_after_active", 32'(act_a), 32'd0);
    bus_a.req0_valid = 1'b0;
    @(negedge clk);
    wait_a(2, 0, "busy_fall_midreset");
    check("words_midreset", 32'(bus_a.words_sent), 32'd1);
    check("bytes_consumed_midreset", exp_byte.size(), 0);

    // GAP_CLKS=0 instance: stray tx_done in IDLE, then one word.
    @(negedge clk); done_b_inj = 1'b1;
    @(negedge clk); done_b_inj = 1'b0;
    act = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_b.tx_dv || bus_b.busy) act++;
    end
    check("stray_done_activity", act, 0);
    check("stray_done_words", 32'(bus_b.words_sent), 32'd0);
    wb = 32'h01020304;
    bus_b.req0_data = wb; bus_b.req0_valid = 1'b1;
    n = 0;
    while (!bus_b.req0_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus_b.req0_ready) fail("timeout_ready0_b");
    bus_b.req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus_b.tx_dv && n < 100) begin @(negedge clk); n++; end
      if (!bus_b.tx_dv) fail("timeout_dv_b");
      else begin
        check("b_tx_byte", 32'(bus_b.tx_byte), 32'(wb[8*i +: 8]));
        check("b_grant_id", 32'(bus_b.grant_id), 32'd0);
        if (i > 0) check("b_done_to_dv", cyc - done_b_cyc, 2);
      end
      @(negedge clk);
    end
    n = 0;
    while (bus_b.busy && n < 100) begin @(negedge clk); n++; end
    check("b_busy_fall", 32'(bus_b.busy), 32'd0);
    check("b_words", 32'(bus_b.words_sent), 32'd1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (UART_Tx byte engine) between two 32-bit word requesters, e.g. requester 0 = CPU MMIO UART port, requester 1 = DM dump engine.
- Accepts a word from the granted requester and serializes it LSB byte first as four UART_Tx transfers.
- Enforces a configurable idle gap between bytes.
- Sits between the requesters and the UART_Tx instance in the external-devices layer.

Parameters:
- GAP_CLKS, 16'd16, idle clocks inserted after each byte's tx_done before the next tx_dv; 0 = no gap.
- GAP_BITS, 16, width of the gap counter; GAP_CLKS must fit.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 holds a word to send
- req0_data  input  32  requester 0 word
- req0_ready  output  1  one-cycle pulse: req0_data accepted this cycle
- req1_valid  input  1  requester 1 holds a word to send
- req1_data  input  32  requester 1 word
- req1_ready  output  1  one-cycle pulse: req1_data accepted this cycle
- grant_id  output  1  requester whose word is currently being sent
- busy  output  1  high from acceptance until the last byte's gap completes
- tx_dv  output  1  one-cycle start pulse to UART_Tx
- tx_byte  output  8  byte to UART_Tx; valid with tx_dv and stable until the next pulse
- tx_active  input  1  UART_Tx shifting
- tx_done  input  1  UART_Tx one-cycle completion pulse
- words_sent  output  16  count of fully transmitted words, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values: req0_ready=0, req1_ready=0, grant_id=0, busy=0, tx_dv=0, tx_byte=8'h00, words_sent=0.
- Reset also sets state=IDLE, byte_cnt=0, gap_cnt=0 and last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - If tx_active=1, wait; this covers a byte still in flight after a mid-transfer reset.
  - Otherwise grant by round-robin. If only one valid, grant it. If both valid, grant ~last_grant.
  - On grant, in the same cycle: latch data into word_buf, pulse reqN_ready, set grant_id=N, last_grant=N, busy=1, byte_cnt=0; go to SEND.
  - The requester must hold valid/data until it sees ready; it may drop valid after ready.
- SEND:
  - Drive tx_byte = word_buf[8*byte_cnt+7 : 8*byte_cnt].
  - Pulse tx_dv for exactly one cycle, then go to WAIT.
  - The first tx_dv for a word occurs one clock after the ready pulse.
- WAIT:
  - On tx_done: if GAP_CLKS=0, go directly to the NEXT decision; else set gap_cnt=0 and go to GAP.
  - tx_done is ignored in every state other than WAIT.
- GAP:
  - Increment gap_cnt each clock; when gap_cnt==GAP_CLKS-1, take the NEXT decision.
- NEXT decision:
  - If byte_cnt==3: words_sent+=1, busy=0, go to IDLE. A new grant is possible in that same IDLE cycle's successor, i.e. no back-to-back cycle.
  - Else: byte_cnt+=1, go to SEND.
- Simultaneous events:
  - A requester asserting valid while busy is not accepted; its ready stays 0 until arbitration in IDLE.
  - Both requesters are never readied in the same cycle.
- reset asserted mid-word: the word is abandoned, with no ready re-pulse and no words_sent increment. After reset the block waits for tx_active low before regranting.
- tx_dv is never asserted while tx_active=1.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIORITY_EN.
- Defined: requester 0 always wins when both are valid; last_grant is unused.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single word, GAP_CLKS=4: req0_valid=1, req0_data=32'hA1B2C3D4; tx model asserts tx_done 10 clocks after each tx_dv. Required:
  - req0_ready pulses once.
  - tx_byte sequence 8'hD4, C3, B2, A1.
  - Four tx_dv pulses spaced 10+4+1 clocks.
  - words_sent=1, busy falls after the last gap.
- Round-robin: both valid continuously, req0_data=32'h11111111, req1_data=32'h22222222. Required:
  - Grants alternate 0,1,0,1 over 4 words.
  - grant_id matches the bytes sent.
  - words_sent=4.
- Fixed priority (macro defined): same stimulus as round-robin. Required: four consecutive grants to requester 0; requester 1 is never readied while req0_valid=1.
- Late request: req1_valid raised during byte 2 of a req0 word. Required: req1_ready=0 until the req0 word completes, then req1_ready is pulsed on the next IDLE arbitration cycle.
- Reset mid-word: reset 1 cycle after the 2nd tx_dv while tx_active=1 for 6 more clocks. Required:
  - All outputs return to reset values.
  - No tx_dv until tx_active falls.
  - Pending req0 is regranted and its word resent from byte 0 (8'hD4).
- GAP_CLKS=0 and stray tx_done:
  - With GAP_CLKS=0, the next tx_dv follows tx_done by exactly 2 clocks.
  - A tx_done injected in IDLE causes no state change and no words_sent increment.
